change_dispenser: RTL

- Downstream of the vending core; consumes the 16-bit change amount the core produces when a sale completes.
- Breaks that amount into physical coin/note denominations using a greedy algorithm against per-denomination stock counters.
- Issues one denomination unit per valid/ready handshake to the payout mechanism.
- Reports any amount it could not pay out (shortfall) when the transaction completes.

---
 rtl/change_dispenser.sv | 163 ++++++++++++++++
 1 files changed

// File: rtl/change_dispenser.sv
// change_dispenser: breaks a change amount into coin/note units by a greedy
// walk over seven denominations (largest first), issuing one unit per
// valid/ready handshake. Per-denomination stock counters limit the payout.
// Whatever cannot be paid is reported at the end of the transaction.
module change_dispenser #(
    parameter int AMTW       = 16,
    parameter int STOCKW     = 8,
    parameter int INIT_STOCK = 20
) (
    input  logic              clk,
    input  logic              rstn,
    input  logic              chg_valid,
    input  logic [AMTW-1:0]   chg_amount,
    output logic              chg_ready,
    output logic              den_valid,
    output logic [2:0]        den_code,
    input  logic              den_ready,
    output logic              done,
    output logic              shortfall,
    output logic [AMTW-1:0]   short_amt,
    input  logic              refill_valid,
    input  logic [2:0]        refill_sel,
    input  logic [STOCKW-1:0] refill_cnt
);

    localparam int NDEN = 7;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        SELECT = 2'd1,
        ISSUE  = 2'd2,
        DONE   = 2'd3
    } state_t;

    // Face value of each denomination code; code 7 never reaches the lookup.
    function automatic logic [AMTW-1:0] den_value(input logic [2:0] code);
        case (code)
            3'd0:    den_value = AMTW'(100);
            3'd1:    den_value = AMTW'(50);
            3'd2:    den_value = AMTW'(20);
            3'd3:    den_value = AMTW'(10);
            3'd4:    den_value = AMTW'(5);
            3'd5:    den_value = AMTW'(2);
            3'd6:    den_value = AMTW'(1);
            default: den_value = '0;
        endcase
    endfunction

    state_t            r_state;
    logic [AMTW-1:0]   r_rem;
    logic [2:0]        r_idx;
    logic              r_chg_ready;
    logic              r_den_valid;
    logic [2:0]        r_den_code;
    logic              r_done;
    logic              r_shortfall;
    logic [AMTW-1:0]   r_short_amt;
    logic [STOCKW-1:0] r_stock [NDEN];

    logic [STOCKW-1:0] w_stock_nxt [NDEN];
    logic [STOCKW:0]   w_add       [NDEN];
    logic [AMTW-1:0]   w_val;
    logic [STOCKW-1:0] w_cur_stock;
    logic              w_hs;

    assign w_val       = den_value(r_idx);
    assign w_cur_stock = r_stock[r_idx];
    assign w_hs        = (r_state == ISSUE) && r_den_valid && den_ready;

    assign chg_ready = r_chg_ready;
    assign den_valid = r_den_valid;
    assign den_code  = r_den_code;
    assign done      = r_done;
    assign shortfall = r_shortfall;
    assign short_amt = r_short_amt;

    // Next stock per denomination: refill and payout may coincide; the sum is
    // kept one bit wider so overflow can be clamped to all-ones.
    always_comb begin
        for (int i = 0; i < NDEN; i++) begin
            w_add[i] = {1'b0, r_stock[i]};
            if (refill_valid && refill_sel == 3'(i))
                w_add[i] = w_add[i] + {1'b0, refill_cnt};
            if (w_hs && r_idx == 3'(i) && w_add[i] != '0)
                w_add[i] = w_add[i] - (STOCKW+1)'(1);
            w_stock_nxt[i] = w_add[i][STOCKW] ? '1 : w_add[i][STOCKW-1:0];
        end
    end

    // Stock counters: reset to the initial fill, otherwise take the next value.
    always_ff @(posedge clk) begin
        for (int i = 0; i < NDEN; i++) begin
            if (!rstn) r_stock[i] <= STOCKW'(INIT_STOCK);
            else       r_stock[i] <= w_stock_nxt[i];
        end
    end

    // Transaction FSM with registered handshake and status outputs.
    always_ff @(posedge clk) begin
        if (!rstn) begin
            r_state     <= IDLE;
            r_rem       <= '0;
            r_idx       <= '0;
            r_chg_ready <= 1'b0;
            r_den_valid <= 1'b0;
            r_den_code  <= '0;
            r_done      <= 1'b0;
            r_shortfall <= 1'b0;
            r_short_amt <= '0;
        end else begin
            case (r_state)
                IDLE: begin
                    r_chg_ready <= 1'b1;
                    if (chg_valid && r_chg_ready) begin
                        r_rem       <= chg_amount;
                        r_idx       <= '0;
                        r_chg_ready <= 1'b0;
                        if (chg_amount != '0) begin
                            r_state <= SELECT;
                        end else begin
                            // Nothing to pay: finish immediately with no shortfall.
                            r_state     <= DONE;
                            r_done      <= 1'b1;
                            r_shortfall <= 1'b0;
                            r_short_amt <= '0;
                        end
                    end
                end
                SELECT: begin
                    if (w_val <= r_rem && w_cur_stock != '0) begin
                        r_state     <= ISSUE;
                        r_den_valid <= 1'b1;
                        r_den_code  <= r_idx;
                    end else if (r_rem == '0 || r_idx == 3'd6) begin
                        r_state     <= DONE;
                        r_done      <= 1'b1;
                        r_shortfall <= (r_rem != '0);
                        r_short_amt <= r_rem;
                    end else begin
                        r_idx <= r_idx + 3'd1;
                    end
                end
                ISSUE: begin
                    // Stay on the same index afterwards so a denomination can repeat.
                    if (w_hs) begin
                        r_rem       <= r_rem - w_val;
                        r_den_valid <= 1'b0;
                        r_state     <= SELECT;
                    end
                end
                DONE: begin
                    r_done      <= 1'b0;
                    r_shortfall <= 1'b0;
                    r_short_amt <= '0;
                    r_chg_ready <= 1'b1;
                    r_state     <= IDLE;
                end
                default: r_state <= IDLE;
            endcase
        end
    end

endmodule
